// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int   WORD_BYTES  = 8;
    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a sole requester always wins, and on a tie
// the port that was not granted last time wins.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // One-hot winner selection
    always_comb begin
        gnt = 2'b00;
        if (req[PORT_CORE] && req[PORT_LOADER]) begin
            if (last_grant == PORT_LOADER) begin
                gnt[PORT_CORE] = 1'b1;
            end else begin
                gnt[PORT_LOADER] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port 64-bit data memory between the core load/store
// path (port 0) and the loader/debug path (port 1). Each access takes
// three cycles: grant in IDLE, one memory cycle, one response cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a request; grant pulses combinationally here
// ACCESS | latched operands drive the memory; strobes held off on error
// RESP   | rvalid/rdata/err presented to the port that was granted
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    // Highest legal word address; compared at full width so high address
    // bits can never alias into the memory.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              id_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              accept;
    logic              win_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    // Grants only leave the block in IDLE and never while reset is held
    assign gnt       = (state_q == IDLE && !rst) ? arb_gnt : 2'b00;
    assign accept    = |gnt;
    assign win_id    = gnt[PORT_LOADER];
    assign sel_we    = (win_id == PORT_LOADER) ? m1_we    : m0_we;
    assign sel_addr  = (win_id == PORT_LOADER) ? m1_addr  : m0_addr;
    assign sel_wdata = (win_id == PORT_LOADER) ? m1_wdata : m0_wdata;
    assign sel_err   = (sel_addr[2:0] != 3'b000) || (sel_addr > MAX_ADDR);

    assign m0_gnt = gnt[PORT_CORE];
    assign m1_gnt = gnt[PORT_LOADER];
    assign busy   = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, memory strobes and response mux
    always_comb begin
        state_d        = state_q;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        m0_rvalid      = 1'b0;
        m0_rdata       = '0;
        m0_err         = 1'b0;
        m1_rvalid      = 1'b0;
        m1_rdata       = '0;
        m1_err         = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                if (!err_q) begin
                    mem_write = we_q;
                    mem_read  = !we_q;
                end
                state_d = RESP;
            end
            RESP: begin
                if (id_q == PORT_CORE) begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = rdata_q;
                    m0_err    = err_q;
                end else begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = rdata_q;
                    m1_err    = err_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latches, round-robin history and registered load data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PORT_LOADER;
            id_q         <= PORT_CORE;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= win_id;
                id_q         <= win_id;
                we_q         <= sel_we;
                err_q        <= sel_err;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (!we_q && !err_q) ? mem_read_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory model, directed vector table,
// hand-written arbitration/reset sequences and a randomized phase checked
// against a word-level reference model.
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [63:0] m0_rdata, m1_rdata;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m0_err         (m0_err),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .m1_err         (m1_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    // Data memory: little-endian byte array, synchronous write, combinational read
    logic [7:0] mem [0:MEM_BYTES-1];
    logic       tb_clear;

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (mem_write && mem_address <= 64'(MEM_BYTES - 8)) begin
            for (int b = 0; b < 8; b++) mem[int'(mem_address) + b] <= mem_write_data[8*b +: 8];
        end
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_address <= 64'(MEM_BYTES - 8)) begin
            for (int b = 0; b < 8; b++) mem_read_data[8*b +: 8] = mem[int'(mem_address) + b];
        end
    end

    // Reference model: memory as an array of 64-bit words plus the last winner
    logic [63:0] ref_mem [0:MEM_BYTES/8-1];
    logic        model_last;

    function automatic void model_access(input logic we, input logic [63:0] addr,
                                         input logic [63:0] wdata,
                                         output logic [63:0] rd, output logic err);
        err = (addr % 8 != 0) || (addr > 64'(MEM_BYTES - 8));
        rd  = 64'h0;
        if (!err) begin
            if (we) ref_mem[int'(addr / 8)] = wdata;
            else    rd = ref_mem[int'(addr / 8)];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_port(input logic p, input logic req, input logic we,
                            input logic [63:0] addr, input logic [63:0] wdata);
        if (p == 1'b0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic drop_req(input logic p);
        if (p == 1'b0) m0_req = 1'b0;
        else           m1_req = 1'b0;
    endtask

    task automatic check_access(input string name, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic err);
        chk({name, " mem_read"},  64'(mem_read),  64'(!we && !err));
        chk({name, " mem_write"}, 64'(mem_write), 64'(we && !err));
        chk({name, " mem_address"}, mem_address, addr);
        chk({name, " mem_write_data"}, mem_write_data, wdata);
        chk({name, " busy in access"}, 64'(busy), 64'(1));
        chk({name, " early rvalid"}, 64'({m1_rvalid, m0_rvalid}), 64'(0));
        chk({name, " gnt in access"}, 64'({m1_gnt, m0_gnt}), 64'(0));
    endtask

    task automatic check_resp(input string name, input logic p, input logic [63:0] rd,
                              input logic err);
        chk({name, " rvalid"}, 64'({m1_rvalid, m0_rvalid}), p ? 64'(2) : 64'(1));
        chk({name, " rdata"}, p ? m1_rdata : m0_rdata, rd);
        chk({name, " other rdata"}, p ? m0_rdata : m1_rdata, 64'h0);
        chk({name, " err"}, 64'({m1_err, m0_err}), p ? 64'({err, 1'b0}) : 64'({1'b0, err}));
        chk({name, " strobes in resp"}, 64'({mem_read, mem_write}), 64'(0));
        chk({name, " mem_address in resp"}, mem_address, 64'h0);
        chk({name, " gnt in resp"}, 64'({m1_gnt, m0_gnt}), 64'(0));
    endtask

    // Single uncontested access; entered just after a posedge with the FSM idle
    task automatic run_single(input string name, input logic p, input logic we,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rd, input logic exp_err);
        set_port(p, 1'b1, we, addr, wdata);
        @(negedge clk);
        chk({name, " gnt"}, 64'({m1_gnt, m0_gnt}), p ? 64'(2) : 64'(1));
        model_last = p;
        @(posedge clk); #1;
        drop_req(p);
        @(negedge clk);
        check_access(name, we, addr, wdata, exp_err);
        @(posedge clk); #1;
        @(negedge clk);
        check_resp(name, p, exp_rd, exp_err);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1'b1;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    logic        pend   [2];
    logic        pwe    [2];
    logic [63:0] paddr  [2];
    logic [63:0] pwdata [2];

    initial begin
        logic [63:0] erd;
        logic        eerr;
        logic        w;
        int          n;
        int          last_cyc;
        int          sel;

        vecs[0]  = '{1'b0, 1'b1, 64'h10,          64'hDEADBEEF_CAFEF00D, 64'h0,                 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 64'h10,          64'h0,                 64'hDEADBEEF_CAFEF00D, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 64'h13,          64'h0,                 64'h0,                 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 64'h3F8,         64'h0,                 64'h0,                 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 64'h400,         64'h0,                 64'h0,                 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 64'h1_0000_0000, 64'h0,                 64'h0,                 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 64'h3F9,         64'h0,                 64'h0,                 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 64'h20,          64'hFFFF_FFFF_FFFF_FFFF, 64'h0,               1'b0};
        vecs[8]  = '{1'b0, 1'b0, 64'h20,          64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 64'h3F8,         64'h01234567_89ABCDEF, 64'h0,                 1'b0};
        vecs[10] = '{1'b1, 1'b0, 64'h3F8,         64'h0,                 64'h01234567_89ABCDEF, 1'b0};

        for (int i = 0; i < MEM_BYTES / 8; i++) ref_mem[i] = 64'h0;
        m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        tb_clear = 1'b1;
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b1;

        // Reset state, including a request that must not be granted under reset
        @(negedge clk);
        chk("reset gnt", 64'({m1_gnt, m0_gnt}), 64'(0));
        chk("reset rvalid", 64'({m1_rvalid, m0_rvalid}), 64'(0));
        chk("reset err", 64'({m1_err, m0_err}), 64'(0));
        chk("reset rdata", m0_rdata | m1_rdata, 64'h0);
        chk("reset strobes", 64'({mem_read, mem_write}), 64'(0));
        chk("reset mem_address", mem_address, 64'h0);
        chk("reset busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        tb_clear = 1'b0;
        do_reset();

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, erd, eerr);
            run_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
                       vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Contested requests after reset: strict alternation starting with port 0
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
        set_port(1'b1, 1'b1, 1'b0, 64'h8, 64'h0);
        n = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                chk($sformatf("tie grant %0d", n), 64'({m1_gnt, m0_gnt}),
                    (n % 2 == 1) ? 64'(2) : 64'(1));
                if (n > 0) chk($sformatf("tie gap %0d", n), 64'(cyc - last_cyc), 64'(3));
                last_cyc = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        chk("tie grant count", 64'(n), 64'(10));
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        model_last = 1'b1;

        // Randomized traffic; a losing requester keeps its request up until granted
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int it = 0; it < 220; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && it < 210 && $urandom_range(0, 99) < 55) begin
                    pend[p]   = 1'b1;
                    pwe[p]    = 1'($urandom_range(0, 1));
                    pwdata[p] = {$urandom, $urandom};
                    sel = $urandom_range(0, 9);
                    if (sel < 7)       paddr[p] = 64'($urandom_range(0, 127)) * 8;
                    else if (sel == 7) paddr[p] = 64'($urandom_range(0, 127)) * 8 + 64'($urandom_range(1, 7));
                    else if (sel == 8) begin
                        case ($urandom_range(0, 2))
                            0:       paddr[p] = 64'h3F8;
                            1:       paddr[p] = 64'h3F9;
                            default: paddr[p] = 64'h400;
                        endcase
                    end else paddr[p] = {$urandom, $urandom};
                    set_port(1'(p), 1'b1, pwe[p], paddr[p], pwdata[p]);
                end
            end
            @(negedge clk);
            if (!pend[0] && !pend[1]) begin
                chk("rand idle gnt", 64'({m1_gnt, m0_gnt}), 64'(0));
                chk("rand idle busy", 64'(busy), 64'(0));
                @(posedge clk); #1;
                continue;
            end
            w = (pend[0] && pend[1]) ? !model_last : pend[1];
            chk($sformatf("rand%0d gnt", it), 64'({m1_gnt, m0_gnt}), w ? 64'(2) : 64'(1));
            model_access(pwe[w], paddr[w], pwdata[w], erd, eerr);
            model_last = w;
            @(posedge clk); #1;
            pend[w] = 1'b0;
            drop_req(w);
            @(negedge clk);
            check_access($sformatf("rand%0d", it), pwe[w], paddr[w], pwdata[w], eerr);
            @(posedge clk); #1;
            @(negedge clk);
            check_resp($sformatf("rand%0d", it), w, erd, eerr);
            @(posedge clk); #1;
        end

        // Reset in the middle of ACCESS
        set_port(1'b0, 1'b1, 1'b0, 64'h10, 64'h0);
        @(negedge clk);
        chk("rst-mid gnt", 64'({m1_gnt, m0_gnt}), 64'(1));
        @(posedge clk); #1;
        drop_req(1'b0);
        chk("rst-mid read before reset", 64'(mem_read), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("rst-mid strobes", 64'({mem_read, mem_write}), 64'(0));
        chk("rst-mid busy", 64'(busy), 64'(0));
        chk("rst-mid mem_address", mem_address, 64'h0);
        set_port(1'b0, 1'b1, 1'b0, 64'h10, 64'h0);
        set_port(1'b1, 1'b1, 1'b0, 64'h18, 64'h0);
        #1;
        chk("rst-mid gnt under reset", 64'({m1_gnt, m0_gnt}), 64'(0));
        repeat (2) begin
            @(negedge clk);
            chk("rst-mid no rvalid", 64'({m1_rvalid, m0_rvalid}), 64'(0));
            @(posedge clk);
        end
        #1 rst = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        chk("rst-mid tie after reset", 64'({m1_gnt, m0_gnt}), 64'(1));
        model_access(1'b0, 64'h10, 64'h0, erd, eerr);
        model_last = 1'b0;
        @(posedge clk); #1;
        drop_req(1'b0);
        @(negedge clk);
        check_access("rst-mid p0", 1'b0, 64'h10, 64'h0, eerr);
        @(posedge clk); #1;
        @(negedge clk);
        check_resp("rst-mid p0", 1'b0, erd, eerr);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst-mid p1 gnt", 64'({m1_gnt, m0_gnt}), 64'(2));
        model_access(1'b0, 64'h18, 64'h0, erd, eerr);
        @(posedge clk); #1;
        drop_req(1'b1);
        @(negedge clk);
        check_access("rst-mid p1", 1'b0, 64'h18, 64'h0, eerr);
        @(posedge clk); #1;
        @(negedge clk);
        check_resp("rst-mid p1", 1'b1, erd, eerr);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
